// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory arbiter: FSM states, access size codes, IO window select.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam int         SZ_U = 2;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  // Index of the final byte of an access of the given size.
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Load result formatting: keeps the low 1/2/4 bytes and sign- or zero-extends to 32 bits.
module mem_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [31:0] bytes_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = bytes_i;
    case (size_i[1:0])
      SZ_B:    res_o = {{24{bytes_i[7] & ~size_i[SZ_U]}}, bytes_i[7:0]};
      SZ_H:    res_o = {{16{bytes_i[15] & ~size_i[SZ_U]}}, bytes_i[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM/IO port between instruction fetch and the data port.
// Optional `MEM_ARB_IO_STALL_EN holds IO-window stores off while the IO output FIFO is full.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_SEL     = IO_SEL_DEFAULT,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic                  dp_valid,
  input  logic                  dp_wr,
  input  logic [2:0]            dp_size,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  logic [31:0]           dp_value,
  output logic                  dp_ready,
  output logic [31:0]           dp_res,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a requester raises valid with its payload and holds both until the
  // matching ready pulse; the arbiter accepts only in IDLE, so a valid still high
  // during the DONE cycle is never taken twice.

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [2:0]            size_q, size_d;
  logic                  is_if_q, is_if_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_ready_q, if_ready_d;
  logic                  dp_ready_q, dp_ready_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           dp_res_q, dp_res_d;

  logic [31:0] rd_bytes;
  logic [31:0] ext_res;
  logic [1:0]  cnt_nx;
  logic        last;
  logic        dp_stall;
  logic        dp_go;

`ifdef MEM_ARB_IO_STALL_EN
  assign dp_stall = dp_wr && (dp_addr[17:16] == IO_SEL) && io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign dp_stall       = 1'b0;
`endif

  assign dp_go  = dp_valid && !dp_stall;
  assign cnt_nx = cnt_q + 2'd1;
  assign last   = (cnt_q == last_idx(size_q[1:0]));

  // Byte assembly including the byte arriving on this edge.
  always_comb begin
    rd_bytes = data_q;
    rd_bytes[{cnt_q, 3'b000} +: 8] = mem_din;
  end

  mem_load_extend u_ext (
    .size_i  (size_q),
    .bytes_i (rd_bytes),
    .res_o   (ext_res)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    size_d     = size_q;
    is_if_d    = is_if_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_ready_d = 1'b0;
    dp_ready_d = 1'b0;
    if_data_d  = if_data_q;
    dp_res_d   = dp_res_q;
    case (state_q)
      ST_IDLE: begin
        if (!clear_in && dp_go) begin
          addr_d  = dp_addr;
          size_d  = dp_size;
          is_if_d = 1'b0;
          cnt_d   = 2'd0;
          mem_a_d = dp_addr;
          if (dp_wr) begin
            state_d    = ST_WRITE;
            data_d     = dp_value;
            mem_wr_d   = 1'b1;
            mem_dout_d = dp_value[7:0];
          end else begin
            state_d = ST_READ;
            data_d  = 32'd0;
          end
        end else if (!clear_in && if_valid) begin
          state_d = ST_READ;
          addr_d  = if_addr;
          size_d  = {1'b0, SZ_W};
          is_if_d = 1'b1;
          cnt_d   = 2'd0;
          data_d  = 32'd0;
          mem_a_d = if_addr;
        end
      end
      ST_READ: begin
        if (clear_in) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else begin
          data_d = rd_bytes;
          if (last) begin
            state_d = ST_DONE;
            cnt_d   = 2'd0;
            if (is_if_q) begin
              if_ready_d = 1'b1;
              if_data_d  = rd_bytes;
            end else begin
              dp_ready_d = 1'b1;
              dp_res_d   = ext_res;
            end
          end else begin
            cnt_d   = cnt_nx;
            mem_a_d = addr_q + ADDR_WIDTH'(cnt_nx);
          end
        end
      end
      ST_WRITE: begin
        // Committed stores always finish; clear_in is not looked at here.
        if (last) begin
          state_d    = ST_DONE;
          cnt_d      = 2'd0;
          mem_wr_d   = 1'b0;
          dp_ready_d = 1'b1;
        end else begin
          cnt_d      = cnt_nx;
          mem_a_d    = addr_q + ADDR_WIDTH'(cnt_nx);
          mem_dout_d = data_q[{cnt_nx, 3'b000} +: 8];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      size_q     <= 3'd0;
      is_if_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dp_ready_q <= 1'b0;
      if_data_q  <= 32'd0;
      dp_res_q   <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      is_if_q    <= is_if_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_ready_q <= if_ready_d;
      dp_ready_q <= dp_ready_d;
      if_data_q  <= if_data_d;
      dp_res_q   <= dp_res_d;
    end
  end

  // A frozen cycle must never write, even with a store in flight.
  assign mem_wr      = mem_wr_q & rdy_in;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign if_ready    = if_ready_q;
  assign dp_ready    = dp_ready_q;
  assign if_data     = if_data_q;
  assign dp_res      = dp_res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, transaction-level reference memory and per-cycle compare.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_valid, if_ready;
  logic [31:0] if_addr, if_data;
  logic        dp_valid, dp_wr, dp_ready;
  logic [2:0]  dp_size;
  logic [31:0] dp_addr, dp_value, dp_res;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic [1:0]  dbg_state;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear_in       (clear_in),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_data        (if_data),
    .dp_valid       (dp_valid),
    .dp_wr          (dp_wr),
    .dp_size        (dp_size),
    .dp_addr        (dp_addr),
    .dp_value       (dp_value),
    .dp_ready       (dp_ready),
    .dp_res         (dp_res),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .dbg_state_o    (dbg_state)
  );

  // RAM seen by the DUT, and the reference contents the bench expects.
  logic [7:0]  ram     [0:8191];
  logic [7:0]  ref_mem [0:8191];
  logic        pl_we = 1'b0;
  logic [12:0] pl_a  = 13'd0;
  logic [7:0]  pl_d  = 8'd0;

  assign mem_din = ram[mem_a[12:0]];

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[12:0]] <= mem_dout;
    if (pl_we)  ram[pl_a] <= pl_d;
  end

  logic [31:0] exp_if_q [$];
  logic [32:0] exp_dp_q [$];
  logic [39:0] exp_wr_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_cycles = 0;
  int if_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] size);
    if (size[1:0] == 2'd0) return 1;
    if (size[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  // Load value from the reference memory, extended arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] val;
    logic [31:0] a;
    int n;
    n = nbytes(size);
    val = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      val = val | (32'(ref_mem[a[12:0]]) << (8 * i));
    end
    if (!size[2] && n == 1 && val >= 32'd128)   val = val - 32'd256;
    if (!size[2] && n == 2 && val >= 32'd32768) val = val - 32'd65536;
    return val;
  endfunction

  always @(negedge clk_in) begin
    logic [39:0] w;
    logic [32:0] d;
    logic [31:0] f;
    if (rst_in) begin
      if (if_ready && dp_ready) chk("one_ready", {30'd0, if_ready, dp_ready}, 32'd1);
      if (!rdy_in) chk("wr_while_frozen", {31'd0, mem_wr}, 32'd0);
      if (if_ready) begin
        if_pulses++;
        if (exp_if_q.size() == 0) chk("if_ready_unexpected", {31'd0, if_ready}, 32'd0);
        else begin
          f = exp_if_q.pop_front();
          chk("if_data", if_data, f);
        end
      end
      if (dp_ready) begin
        if (exp_dp_q.size() == 0) chk("dp_ready_unexpected", {31'd0, dp_ready}, 32'd0);
        else begin
          d = exp_dp_q.pop_front();
          if (d[32]) chk("dp_res", dp_res, d[31:0]);
        end
      end
      if (mem_wr) begin
        wr_cycles++;
        if (exp_wr_q.size() == 0) chk("mem_wr_unexpected", {31'd0, mem_wr}, 32'd0);
        else begin
          w = exp_wr_q.pop_front();
          chk("wr_addr", mem_a, w[39:8]);
          chk("wr_byte", {24'd0, mem_dout}, {24'd0, w[7:0]});
        end
      end
    end
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk_in);
    pl_we = 1'b1; pl_a = a[12:0]; pl_d = d;
    ref_mem[a[12:0]] = d;
    @(posedge clk_in);
    #1 pl_we = 1'b0;
  endtask

  // Starts at an accept edge; counts edges until the selected ready is seen.
  // ev_kind: 1 freeze rdy_in for 3 edges, 2 pulse clear_in, 3 release io_buffer_full.
  task automatic wait_ready(input logic is_dp, input int ev_kind, input int ev_at, output int lat);
    bit done;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 60) begin
      #1;
      if (is_dp ? dp_ready : if_ready) done = 1'b1;
      else begin
        if (ev_kind == 1 && lat == ev_at)     rdy_in = 1'b0;
        if (ev_kind == 1 && lat == ev_at + 3) rdy_in = 1'b1;
        if (ev_kind == 2 && lat == ev_at)     clear_in = 1'b1;
        if (ev_kind == 2 && lat == ev_at + 1) clear_in = 1'b0;
        if (ev_kind == 3 && lat == ev_at)     io_buffer_full = 1'b0;
        @(posedge clk_in);
        lat++;
      end
    end
    if (!done) chk("ready_timeout", 32'(lat), 32'd0);
    rdy_in = 1'b1;
    clear_in = 1'b0;
  endtask

  task automatic run_dp(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] value, input int ev_kind, input int ev_at,
                        output logic [31:0] res, output int lat);
    logic [31:0] a;
    int n;
    n = nbytes(size);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        exp_wr_q.push_back({a, value[8*i +: 8]});
        ref_mem[a[12:0]] = value[8*i +: 8];
      end
      exp_dp_q.push_back({1'b0, 32'd0});
    end else begin
      exp_dp_q.push_back({1'b1, model_load(size, addr)});
    end
    @(negedge clk_in);
    dp_valid = 1'b1; dp_wr = wr; dp_size = size; dp_addr = addr; dp_value = value;
    @(posedge clk_in);
    wait_ready(1'b1, ev_kind, ev_at, lat);
    res = dp_res;
    dp_valid = 1'b0;
    @(posedge clk_in);
  endtask

  task automatic run_if(input logic [31:0] addr, output logic [31:0] res, output int lat);
    exp_if_q.push_back(model_load(3'b010, addr));
    @(negedge clk_in);
    if_valid = 1'b1; if_addr = addr;
    @(posedge clk_in);
    wait_ready(1'b0, 0, 0, lat);
    res = if_data;
    if_valid = 1'b0;
    @(posedge clk_in);
  endtask

  initial begin
    logic [31:0] res;
    int lat, w0, p0, k, dk, ik, lat_io;
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    if_valid = 1'b0; if_addr = 32'd0;
    dp_valid = 1'b0; dp_wr = 1'b0; dp_size = 3'd0; dp_addr = 32'd0; dp_value = 32'd0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_state",    {30'd0, dbg_state}, 32'd0);
    chk("rst_mem_a",    mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_dp_ready", {31'd0, dp_ready}, 32'd0);
    chk("rst_if_data",  if_data, 32'd0);
    chk("rst_dp_res",   dp_res, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h20, 8'hF0);   poke(32'h22, 8'h34);   poke(32'h23, 8'h82);
    poke(32'h24, 8'h11);   poke(32'h25, 8'h22);   poke(32'h26, 8'h33);   poke(32'h27, 8'hC4);
    poke(32'hFFFFFFFE, 8'hA1); poke(32'hFFFFFFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);

    run_if(32'h1000, res, lat);
    chk("if_word_lit", res, 32'h00000513);
    chk("if_lat", 32'(lat), 32'd4);

    run_dp(1'b0, 3'b000, 32'h20, 32'd0, 0, 0, res, lat);
    chk("lb_signed_lit", res, 32'hFFFFFFF0);
    chk("lb_lat", 32'(lat), 32'd1);
    run_dp(1'b0, 3'b100, 32'h20, 32'd0, 0, 0, res, lat);
    chk("lbu_lit", res, 32'h000000F0);
    run_dp(1'b0, 3'b001, 32'h22, 32'd0, 0, 0, res, lat);
    chk("lh_signed_lit", res, 32'hFFFF8234);
    chk("lh_lat", 32'(lat), 32'd2);
    run_dp(1'b0, 3'b101, 32'h22, 32'd0, 0, 0, res, lat);
    chk("lhu_lit", res, 32'h00008234);
    run_dp(1'b0, 3'b010, 32'h24, 32'd0, 0, 0, res, lat);
    chk("lw_lit", res, 32'hC4332211);

    w0 = wr_cycles;
    run_dp(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, res, lat);
    chk("sw_wr_cycles", 32'(wr_cycles - w0), 32'd4);
    chk("sw_lat", 32'(lat), 32'd4);
    run_dp(1'b0, 3'b010, 32'h40, 32'd0, 0, 0, res, lat);
    chk("sw_readback_lit", res, 32'hDEADBEEF);

    // Both requests together: DP first, IF accepted two cycles after dp_ready.
    exp_dp_q.push_back({1'b1, model_load(3'b100, 32'h20)});
    exp_if_q.push_back(model_load(3'b010, 32'h1000));
    @(negedge clk_in);
    dp_valid = 1'b1; dp_wr = 1'b0; dp_size = 3'b100; dp_addr = 32'h20;
    if_valid = 1'b1; if_addr = 32'h1000;
    @(posedge clk_in);
    k = 0; dk = -1; ik = -1;
    while ((dk < 0 || ik < 0) && k < 40) begin
      #1;
      if (k == 0) chk("grant_dp_first", mem_a, 32'h20);
      if (dp_ready) begin dk = k; dp_valid = 1'b0; end
      if (if_ready) begin ik = k; if_valid = 1'b0; end
      if (dk < 0 || ik < 0) begin
        @(posedge clk_in);
        k++;
      end
    end
    chk("both_dp_lat", 32'(dk), 32'd1);
    chk("both_if_lat", 32'(ik), 32'd7);
    @(posedge clk_in);

    // Flush during the second byte of an IF read.
    p0 = if_pulses;
    @(negedge clk_in);
    if_valid = 1'b1; if_addr = 32'h1000;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    chk("clr_second_byte_addr", mem_a, 32'h1001);
    clear_in = 1'b1; if_valid = 1'b0;
    @(posedge clk_in);
    #1;
    clear_in = 1'b0;
    chk("clr_idle_next", {30'd0, dbg_state}, 32'd0);
    repeat (8) @(posedge clk_in);
    chk("clr_no_if_ready", 32'(if_pulses - p0), 32'd0);

    w0 = wr_cycles;
    run_dp(1'b1, 3'b001, 32'h50, 32'h00001234, 2, 1, res, lat);
    chk("clr_store_lat", 32'(lat), 32'd2);
    chk("clr_store_wr_cycles", 32'(wr_cycles - w0), 32'd2);
    run_dp(1'b0, 3'b101, 32'h50, 32'd0, 0, 0, res, lat);
    chk("clr_store_readback_lit", res, 32'h00001234);

    w0 = wr_cycles;
    run_dp(1'b1, 3'b010, 32'h60, 32'hCAFEF00D, 1, 1, res, lat);
    chk("freeze_store_lat", 32'(lat), 32'd7);
    chk("freeze_store_wr_cycles", 32'(wr_cycles - w0), 32'd4);
    run_dp(1'b0, 3'b010, 32'h60, 32'd0, 1, 2, res, lat);
    chk("freeze_load_lit", res, 32'hCAFEF00D);
    chk("freeze_load_lat", 32'(lat), 32'd7);

    run_dp(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, 0, res, lat);
    chk("wrap_load_lit", res, 32'hD4C3B2A1);

`ifdef MEM_ARB_IO_STALL_EN
    lat_io = 6;
`else
    lat_io = 1;
`endif
    io_buffer_full = 1'b1;
    w0 = wr_cycles;
    run_dp(1'b1, 3'b000, 32'h00030000, 32'h0000005A, 3, 4, res, lat);
    io_buffer_full = 1'b0;
    chk("io_store_lat", 32'(lat), 32'(lat_io));
    chk("io_store_wr_cycles", 32'(wr_cycles - w0), 32'd1);

    repeat (4) @(posedge clk_in);
    #1;
    chk("exp_if_q_drained", 32'(exp_if_q.size()), 32'd0);
    chk("exp_dp_q_drained", 32'(exp_dp_q.size()), 32'd0);
    chk("exp_wr_q_drained", 32'(exp_wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
